// File: rtl/qsys_system_button_pio_pkg.sv
// Shared definitions for the button input PIO: register offsets, edge-type
// encodings and a sizing helper for the debounce counter.
package qsys_system_button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_UNUSED  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must hold 0..n; at least one bit even when debounce is bypassed.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qsys_system_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO register file.
interface qsys_system_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/qsys_system_button_pio_debounce_bit.sv
// One button bit: two-flop synchroniser followed by a consecutive-sample
// debouncer that only accepts a new level after DEBOUNCE_CYCLES mismatches.
module pio_debounce_bit
  import qsys_system_button_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o
);

  logic sync1_q, sync2_q;
  logic deb_q, deb_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb deb_d = sync2_q;
    end else begin : g_count
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      logic [CW-1:0] cnt_q, cnt_d;

      // Any sample that agrees with deb restarts the run, so the count
      // never passes DEBOUNCE_CYCLES-1 and never wraps.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
          else                                   cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign deb_o = deb_q;

endmodule

// File: rtl/qsys_system_button_pio.sv
// Avalon-MM input PIO for front-panel buttons: debounced level, edge capture
// with write-1-to-clear, interrupt mask and a level IRQ.
module qsys_system_button_pio
  import qsys_system_button_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  qsys_system_button_pio_if.slave  avs,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d_q;
  logic [WIDTH-1:0] rise, fall, hit;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port[i]),
        .deb_o   (deb[i])
      );
    end
  endgenerate

  assign rise = deb & ~deb_d_q;
  assign fall = ~deb & deb_d_q;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      default:   hit = rise;
    endcase
  end

  assign wr           = avs.chipselect & ~avs.write_n;
  assign unused_wdata = ^avs.writedata;

  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && avs.address == ADDR_IRQMASK) irqmask_d = avs.writedata[WIDTH-1:0];
    if (wr && avs.address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~avs.writedata[WIDTH-1:0];
    // New edges are OR'd in after the clear so a colliding edge is kept.
    edgecap_d = edgecap_d | hit;
  end

  always_comb begin
    readdata_d = '0;
    case (avs.address)
      ADDR_DATA:    readdata_d = 32'(deb);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d_q    <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      deb_d_q    <= deb;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule
